// File: rtl/present_round_engine_pkg.sv
// Shared widths, round-count constants and the FSM state encoding for the
// PRESENT encrypt engine (also intended for reuse by the decrypt engine).
package present_round_engine_pkg;

   localparam int BLOCK_W    = 64;
   localparam int KEY_W      = 80;
   localparam int NUM_ROUNDS = 31;
   localparam int RND_W      = 5;
   localparam int NIBBLES    = BLOCK_W / 4;

   // Last RUN round index and the key-table entry used for final whitening
   localparam logic [RND_W-1:0] LAST_RND  = 5'd30;
   localparam logic [RND_W-1:0] WHITE_IDX = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/present_round_engine_if.sv
// Plaintext-in / ciphertext-out valid/ready streams of the round engine.
interface present_round_engine_if;
   import present_round_engine_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] in_block;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out_block;

   modport master (
      output in_valid, in_block, out_ready,
      input  in_ready, out_valid, out_block
   );

   modport slave (
      input  in_valid, in_block, out_ready,
      output in_ready, out_valid, out_block
   );

endinterface

// File: rtl/present_round_engine_round.sv
// One combinational PRESENT round: pLayer(sLayer(in ^ rk)), built from
// sixteen 4-bit S-boxes and a fixed bit permutation.
module SBox (
   output logic [3:0] out,
   input  logic [3:0] in
);

   // PRESENT 4-bit substitution table
   always_comb begin
      out = 4'h0;
      case (in)
         4'h0:    out = 4'hC;
         4'h1:    out = 4'h5;
         4'h2:    out = 4'h6;
         4'h3:    out = 4'hB;
         4'h4:    out = 4'h9;
         4'h5:    out = 4'h0;
         4'h6:    out = 4'hA;
         4'h7:    out = 4'hD;
         4'h8:    out = 4'h3;
         4'h9:    out = 4'hE;
         4'hA:    out = 4'hF;
         4'hB:    out = 4'h8;
         4'hC:    out = 4'h4;
         4'hD:    out = 4'h7;
         4'hE:    out = 4'h1;
         4'hF:    out = 4'h2;
         default: out = 4'h0;
      endcase
   end

endmodule

module present_round
   import present_round_engine_pkg::*;
(
   output logic [BLOCK_W-1:0] out,
   input  logic [BLOCK_W-1:0] in,
   input  logic [BLOCK_W-1:0] rk
);

   logic [BLOCK_W-1:0] keyed_s;
   logic [BLOCK_W-1:0] sub_s;

   assign keyed_s = in ^ rk;

   for (genvar i = 0; i < NIBBLES; i++) begin : g_sbox
      SBox u_sbox (
         .out (sub_s[4*i +: 4]),
         .in  (keyed_s[4*i +: 4])
      );
   end

   // 16*i mod 63 is a bijection on 0..62 because gcd(16,63)=1; bit 63 stays put
   for (genvar i = 0; i < BLOCK_W - 1; i++) begin : g_perm
      assign out[(16 * i) % (BLOCK_W - 1)] = sub_s[i];
   end
   assign out[BLOCK_W-1] = sub_s[BLOCK_W-1];

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT-80 encrypt engine: one round per cycle, round keys read
// from the external key-schedule table through rk_idx/rk_in.
module present_round_engine
   import present_round_engine_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   present_round_engine_if.slave  bus,
   output logic [RND_W-1:0]       rk_idx,
   input  logic [KEY_W-1:0]       rk_in,
   output logic                   busy
);

   state_t             state_r;
   logic [BLOCK_W-1:0] st_r;
   logic [RND_W-1:0]   rnd_r;
   logic [RND_W-1:0]   rk_idx_r;
   logic               busy_r;
   logic               out_valid_r;
   logic [BLOCK_W-1:0] out_block_r;

   logic [BLOCK_W-1:0] rk_s;
   logic [BLOCK_W-1:0] round_s;
   logic               unused_rk_s;

   // Round key is the top 64 bits of the key-register snapshot
   assign rk_s        = rk_in[KEY_W-1 -: BLOCK_W];
   assign unused_rk_s = ^rk_in[KEY_W-BLOCK_W-1:0];

   present_round u_round (
      .out (round_s),
      .in  (st_r),
      .rk  (rk_s)
   );

   assign bus.in_ready  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & bus.out_ready);
   assign bus.out_valid = out_valid_r;
   assign bus.out_block = out_block_r;
   assign rk_idx        = rk_idx_r;
   assign busy          = busy_r;

   // Control FSM, round counter, cipher state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         st_r        <= 64'h0;
         rnd_r       <= 5'd0;
         rk_idx_r    <= 5'd0;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_block_r <= 64'h0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  st_r     <= bus.in_block;
                  rnd_r    <= 5'd0;
                  rk_idx_r <= 5'd0;
                  busy_r   <= 1'b1;
                  state_r  <= ST_RUN;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               st_r  <= round_s;
               rnd_r <= rnd_r + 5'd1;
               if (rnd_r == LAST_RND) begin
                  rk_idx_r <= WHITE_IDX;
                  state_r  <= ST_FINAL;
               end else begin
                  rk_idx_r <= rnd_r + 5'd1;
                  state_r  <= ST_RUN;
               end
            end
            ST_FINAL: begin
               out_block_r <= st_r ^ rk_s;
               out_valid_r <= 1'b1;
               rk_idx_r    <= 5'd0;
               busy_r      <= 1'b0;
               state_r     <= ST_DONE;
            end
            ST_DONE: begin
               // A waiting plaintext is taken on the same edge the ciphertext leaves
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  if (bus.in_valid) begin
                     st_r    <= bus.in_block;
                     rnd_r   <= 5'd0;
                     busy_r  <= 1'b1;
                     state_r <= ST_RUN;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               rk_idx_r    <= 5'd0;
               busy_r      <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_present_round_engine.sv
// Scoreboard bench for present_round_engine with a loop-level PRESENT-80 model.
module tb_present_round_engine;

   logic        clk;
   logic        rst;
   logic [4:0]  rk_idx;
   logic [79:0] rk_in;
   logic        busy;
   logic [79:0] key_table [32];

   present_round_engine_if bus ();

   present_round_engine dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .rk_idx (rk_idx),
      .rk_in  (rk_in),
      .busy   (busy)
   );

   assign rk_in = key_table[rk_idx];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [63:0] exp_q [$];
   int          acc_q [$];
   logic        prev_valid = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] sb(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   function automatic logic [79:0] next_key(input logic [79:0] k, input int r);
      logic [79:0] n;
      logic [4:0]  rc;
      rc = r[4:0];
      n = {k[18:0], k[79:19]};
      n[79:76] = sb(n[79:76]);
      n[19:15] = n[19:15] ^ rc;
      return n;
   endfunction

   function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] key);
      logic [79:0] k;
      logic [63:0] s, t;
      k = key;
      s = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int i = 0; i < 16; i++) t[4*i +: 4] = sb(s[4*i +: 4]);
         for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16 * i) % 63] = t[i];
         k = next_key(k, r);
      end
      return s ^ k[79:16];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_key(input logic [79:0] key);
      key_table[0] = key;
      for (int j = 1; j < 32; j++) key_table[j] = next_key(key_table[j-1], j);
   endtask

   // Offer one block, push its expected ciphertext on acceptance
   task automatic drive_block(input logic [63:0] pt, input logic [63:0] exp, output int acc_edge);
      int n;
      n = 0;
      acc_edge = -1;
      bus.in_valid = 1'b1;
      bus.in_block = pt;
      @(negedge clk);
      while (!(bus.in_ready && !rst) && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready never high for pt %h", pt);
      end else begin
         acc_edge = cyc + 1;
         exp_q.push_back(exp);
         acc_q.push_back(acc_edge);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input bit rand_ready);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk); #1;
         bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         n++;
      end
      bus.out_ready = 1'b1;
      if (n >= 400) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d ciphertexts outstanding", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!bus.out_valid) begin
         checks++; errors++;
         $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles", bus.out_valid, n);
      end
   endtask

   // Output monitor: latency on rising out_valid, data on each handshake
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
         prev_valid = 1'b0;
      end else begin
         if (bus.out_valid && !prev_valid) begin
            if (acc_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: got %h expected no output", bus.out_block);
            end else begin
               check("latency", 64'(cyc - acc_q.pop_front()), 64'd32);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_transfer: got %h expected nothing", bus.out_block);
            end else begin
               check("ciphertext", bus.out_block, exp_q.pop_front());
            end
         end
         prev_valid = bus.out_valid;
      end
   end

   initial begin
      int a1, a2;
      logic [95:0] rk96;
      logic [79:0] key;
      logic [63:0] pt, pt2;

      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_block = 64'h0;
      bus.out_ready = 1'b1;
      set_key(80'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_block", bus.out_block, 64'h0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rk_idx", 64'(rk_idx), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;

      // Known answer with rk_idx/busy trace
      drive_block(64'h0, 64'h5579C1387B228445, a1);
      for (int k = 0; k <= 32; k++) begin
         @(negedge clk);
         check("rk_idx_trace", 64'(rk_idx), (k <= 30) ? 64'(k) : ((k == 31) ? 64'd31 : 64'd0));
         check("busy_trace", 64'(busy), (k <= 31) ? 64'd1 : 64'd0);
      end
      drain(1'b0);

      set_key(80'hFFFFFFFFFFFFFFFFFFFF);
      drive_block(64'h0, 64'hE72C46C0F5945049, a1);
      drain(1'b0);

      set_key(80'h0);
      drive_block(64'hFFFFFFFFFFFFFFFF, 64'hA112FFC72F68417B, a1);
      drain(1'b0);

      // Backpressure hold
      set_key(80'hFFFFFFFFFFFFFFFFFFFF);
      bus.out_ready = 1'b0;
      drive_block(64'hFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2, a1);
      wait_out_valid();
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_block = 64'h0123456789ABCDEF;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("hold_valid", 64'(bus.out_valid), 64'd1);
         check("hold_block", bus.out_block, 64'h3333DCD3213210D2);
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      drain(1'b0);

      // Back-to-back with in_valid held
      rk96 = {$urandom, $urandom, $urandom};
      key = rk96[79:0];
      pt = {$urandom, $urandom};
      pt2 = {$urandom, $urandom};
      set_key(key);
      drive_block(pt, ref_encrypt(pt, key), a1);
      drive_block(pt2, ref_encrypt(pt2, key), a2);
      check("b2b_spacing", 64'(a2 - a1), 64'd33);
      drain(1'b0);

      // Reset mid-operation at rnd=15
      pt = {$urandom, $urandom};
      drive_block(pt, ref_encrypt(pt, key), a1);
      repeat (15) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("midrst_no_output", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      pt = {$urandom, $urandom};
      drive_block(pt, ref_encrypt(pt, key), a1);
      drain(1'b0);

      // Random keys/plaintexts with random consumer stalls
      for (int n = 0; n < 8; n++) begin
         rk96 = {$urandom, $urandom, $urandom};
         key = rk96[79:0];
         pt = {$urandom, $urandom};
         set_key(key);
         drive_block(pt, ref_encrypt(pt, key), a1);
         drain(1'b1);
      end

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
